bcd_a_binario: RTL



---
 rtl/bcd_a_binario.sv | 89 ++++++++
 1 files changed

// File: rtl/bcd_a_binario.sv
// rtl/bcd_a_binario.sv - sequential BCD-to-binary converter (reverse double dabble)
module bcd_a_binario #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      binario,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int ZW    = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [ZW-1:0]   z;
  logic [CW-1:0]   cnt;
  logic [ZW-1:0]   z_shift;
  logic [ZW-1:0]   z_next;
  logic            bad_digit;

  // One iteration: shift right, then correct each BCD nibble independently.
  always_comb begin
    z_shift = z >> 1;
    z_next  = z_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (z_shift[BIN_W+4*d +: 4] >= 4'd8)
        z_next[BIN_W+4*d +: 4] = z_shift[BIN_W+4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      z       <= '0;
      cnt     <= '0;
      binario <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_digit) begin
              binario <= '0;
              error   <= 1'b1;
              done    <= 1'b1;
            end else begin
              z     <= {bcd, {BIN_W{1'b0}}};
              cnt   <= '0;
              error <= 1'b0;
              busy  <= 1'b1;
              state <= CONV;
            end
          end
        end
        CONV: begin
          z   <= z_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1)) begin
            binario <= z_next[BIN_W-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
